// File: rtl/apb_slave_ws.sv
// APB4 slave front-end for the timer register bank: address decode, programmable
// wait states, registered strobes and read-data return with error response.
module apb_slave_ws #(
    parameter  int ADDR_WIDTH  = 12,
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_REGS    = 8,
    parameter  int WAIT_STATES = 0,
    localparam int STRB_WIDTH  = DATA_WIDTH / 8,
    localparam int IDX_WIDTH   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  tim_psel,
    input  logic                  tim_penable,
    input  logic                  tim_pwrite,
    input  logic [ADDR_WIDTH-1:0] tim_paddr,
    input  logic [DATA_WIDTH-1:0] tim_pwdata,
    input  logic [STRB_WIDTH-1:0] tim_pstrb,
    output logic [DATA_WIDTH-1:0] tim_prdata,
    output logic                  tim_pready,
    output logic                  tim_pslverr,
    input  logic                  reg_error_flag,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic [IDX_WIDTH-1:0]  reg_idx,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [STRB_WIDTH-1:0] reg_wstrb,
    output logic                  wr_en,
    output logic                  rd_en
);

    // Wait-state count saturates at 15 so it always fits the 4-bit counter.
    localparam int              WS_EFF   = (WAIT_STATES > 15) ? 15 : WAIT_STATES;
    localparam logic [3:0]      WS_CNT   = 4'(WS_EFF);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    latch_setup;
    logic                    enter_resp;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    dec_err;
    logic                    read_ok;

    assign word_addr = addr_q >> 2;
    assign dec_err   = (addr_q[1:0] != 2'b00) || (word_addr >= NUM_REGS_A);
    assign read_ok   = enter_resp && !write_q && !dec_err;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        latch_setup = 1'b0;
        enter_resp  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tim_psel && !tim_penable) begin
                    latch_setup = 1'b1;
                    cnt_d       = WS_CNT;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!tim_psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (tim_penable) begin
                    enter_resp = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the transition into RESP, so they are high
    // for exactly the one cycle spent in RESP and zero everywhere else.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            reg_idx     <= '0;
            reg_wdata   <= '0;
            reg_wstrb   <= '0;
            tim_prdata  <= '0;
            tim_pready  <= 1'b0;
            tim_pslverr <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_setup) begin
                addr_q    <= tim_paddr;
                write_q   <= tim_pwrite;
                reg_idx   <= tim_paddr[2 +: IDX_WIDTH];
                reg_wdata <= tim_pwdata;
                reg_wstrb <= tim_pstrb;
            end
            tim_pready  <= enter_resp;
            tim_pslverr <= enter_resp && (dec_err || reg_error_flag);
            wr_en       <= enter_resp && write_q && !dec_err;
            rd_en       <= read_ok;
            tim_prdata  <= read_ok ? reg_rdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_slave_ws.sv
// Self-checking bench: four slaves with different wait-state settings share one APB bus
// and are compared each cycle against a transfer-level model of the expected response.
module tb_apb_slave_ws;

    localparam int N_INST = 4;
    localparam int WS_TAB [N_INST] = '{0, 2, 3, 20};
    localparam int K_FULL = 17;   // access cycles that let the slowest (15-wait) slave finish

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite, err_flag;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [31:0] prdata    [N_INST];
    logic        pready    [N_INST];
    logic        pslverr   [N_INST];
    logic        wr_en     [N_INST];
    logic        rd_en     [N_INST];
    logic [2:0]  reg_idx   [N_INST];
    logic [31:0] reg_wdata [N_INST];
    logic [31:0] reg_rdata [N_INST];
    logic [3:0]  reg_wstrb [N_INST];
    logic [31:0] mem [8];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        apb_slave_ws #(
            .ADDR_WIDTH (12),
            .DATA_WIDTH (32),
            .NUM_REGS   (8),
            .WAIT_STATES(WS_TAB[g])
        ) u_dut (
            .sys_clk       (clk),
            .sys_rst_n     (rst_n),
            .tim_psel      (psel),
            .tim_penable   (penable),
            .tim_pwrite    (pwrite),
            .tim_paddr     (paddr),
            .tim_pwdata    (pwdata),
            .tim_pstrb     (pstrb),
            .tim_prdata    (prdata[g]),
            .tim_pready    (pready[g]),
            .tim_pslverr   (pslverr[g]),
            .reg_error_flag(err_flag),
            .reg_rdata     (reg_rdata[g]),
            .reg_idx       (reg_idx[g]),
            .reg_wdata     (reg_wdata[g]),
            .reg_wstrb     (reg_wstrb[g]),
            .wr_en         (wr_en[g]),
            .rd_en         (rd_en[g])
        );
        // Register bank stand-in: returns the word addressed by the slave's index.
        assign reg_rdata[g] = mem[reg_idx[g]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected {pready, pslverr, wr_en, rd_en, prdata} after edge n of a transfer whose
    // setup was sampled at edge 0 and whose access phase was held for k edges.
    function automatic logic [63:0] exp_out(int ws, int n, int k, bit wr, logic [11:0] addr, bit err);
        int   eff;
        bit   dec;
        logic [35:0] r;
        eff = (ws > 15) ? 15 : ws;
        dec = (addr[1:0] != 2'b00) || ((addr >> 2) >= 12'd8);
        if (n != 1 + eff || 1 + eff > k) return 64'd0;
        r = {1'b1, dec | err, wr & ~dec, ~wr & ~dec, (~wr & ~dec) ? mem[addr[4:2]] : 32'd0};
        return 64'(r);
    endfunction

    task automatic check_outs(string tname, int n, int k, bit wr, logic [11:0] addr, bit err);
        for (int i = 0; i < N_INST; i++)
            check($sformatf("%s ws%0d e%0d out", tname, WS_TAB[i], n),
                  64'({pready[i], pslverr[i], wr_en[i], rd_en[i], prdata[i]}),
                  exp_out(WS_TAB[i], n, k, wr, addr, err));
    endtask

    task automatic check_latched(string tname, logic [11:0] addr, logic [31:0] wd, logic [3:0] st);
        for (int i = 0; i < N_INST; i++)
            check($sformatf("%s ws%0d latched", tname, WS_TAB[i]),
                  64'({reg_idx[i], reg_wstrb[i], reg_wdata[i]}),
                  64'({addr[4:2], st, wd}));
    endtask

    // Bus values during the access phase must not matter; keep them moving.
    task automatic scramble();
        paddr  = 12'($urandom);
        pwdata = $urandom;
        pstrb  = 4'($urandom);
        pwrite = 1'($urandom);
    endtask

    task automatic xfer(string tname, bit wr, logic [11:0] addr, logic [31:0] wd,
                        logic [3:0] st, bit err, int k, bit abort);
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = wd; pstrb = st; err_flag = err;
        @(posedge clk); #1;
        check_outs(tname, 0, k, wr, addr, err);
        check_latched(tname, addr, wd, st);
        penable = 1'b1;
        scramble();
        for (int n = 1; n <= k; n++) begin
            @(posedge clk); #1;
            check_outs(tname, n, k, wr, addr, err);
            scramble();
        end
        check_latched(tname, addr, wd, st);
        if (abort) begin
            psel = 1'b0; penable = 1'b0;
            @(posedge clk); #1;
            check_outs(tname, k + 1, k, wr, addr, err);
        end
    endtask

    initial begin
        bit          wr, err, ab;
        logic [11:0] a;
        int          k;

        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        mem[2] = 32'h1234_5678;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; err_flag = 1'b0;
        #12;
        check_outs("reset", 0, K_FULL, 1'b0, 12'h0, 1'b0);
        check_latched("reset", 12'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer("t1_wr",    1'b1, 12'h004, 32'hA5A5_0001, 4'hF, 1'b0, K_FULL, 1'b0);
        xfer("t2_rd",    1'b0, 12'h008, 32'h0,         4'h0, 1'b0, K_FULL, 1'b0);
        xfer("t3_range", 1'b1, 12'h020, 32'hDEAD_BEEF, 4'hF, 1'b0, K_FULL, 1'b0);
        xfer("t3_misal", 1'b1, 12'h006, 32'hDEAD_BEEF, 4'hF, 1'b0, K_FULL, 1'b0);
        xfer("t3_rdmis", 1'b0, 12'h00D, 32'h0,         4'h0, 1'b0, K_FULL, 1'b0);
        xfer("t4_errfl", 1'b1, 12'h000, 32'h0000_00FF, 4'h3, 1'b1, K_FULL, 1'b0);
        xfer("t4_rderr", 1'b0, 12'h01C, 32'h0,         4'h0, 1'b1, K_FULL, 1'b0);
        xfer("t4_strb0", 1'b1, 12'h010, 32'h5555_AAAA, 4'h0, 1'b0, K_FULL, 1'b0);
        xfer("t5_abort", 1'b1, 12'h00C, 32'h0BAD_F00D, 4'hF, 1'b0, 2,      1'b1);
        xfer("t5_next",  1'b0, 12'h00C, 32'h0,         4'h0, 1'b0, K_FULL, 1'b0);
        xfer("t5_abt0",  1'b0, 12'h014, 32'h0,         4'h0, 1'b0, 0,      1'b1);

        for (int t = 0; t < 30; t++) begin
            wr  = 1'($urandom);
            a   = ($urandom_range(0, 9) < 7) ? {7'd0, 3'($urandom), 2'b00} : 12'($urandom);
            err = ($urandom_range(0, 7) == 0);
            ab  = ($urandom_range(0, 3) == 0);
            k   = ab ? int'($urandom_range(0, 16)) : K_FULL;
            xfer($sformatf("rnd%0d", t), wr, a, $urandom, 4'($urandom), err, k, ab);
        end

        // Reset while the slower slaves are still counting wait states.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010; err_flag = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_outs("t6_rst", 0, K_FULL, 1'b0, 12'h0, 1'b0);
        check_latched("t6_rst", 12'h0, 32'h0, 4'h0);
        psel = 1'b0; penable = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_outs("t6_post", 0, K_FULL, 1'b0, 12'h0, 1'b0);
        xfer("t6_rd", 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, K_FULL, 1'b0);

        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check_outs("idle_end", 0, K_FULL, 1'b0, 12'h0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
